rx_frame_ctrl: RTL and testbench

//  UART receive control unit plus output data buffer. Sequences one serial frame:
//  - start-bit detect, then bit timing, then stop-bit check, then buffer load.
//  - Drives the bit timer (enable_timer) and consumes its packet_done.
//  - Presents the received byte to the host with data_ready/data_read handshake and error flags.

---
 rtl/rx_frame_ctrl_pkg.sv | 23 ++
 rtl/rx_data_buff.sv | 57 +++++
 rtl/rx_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_rx_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared types and constants for the UART receive control slice.
//   rx_state_t        : states of the frame sequencing FSM
//   RX_DATA_BITS_DEF  : default payload width
//   PARITY_ODD        : parity sense used when RX_PARITY_EN is defined
//                       (0 selects even parity)
// ---------------------------------------------------------------------------
package rx_pkg;

  localparam int RX_DATA_BITS_DEF = 8;

  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECEIVE,
    CHECK,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_data_buff.sv
// ---------------------------------------------------------------------------
// rx_data_buff
// Output buffer holding the last good byte for the host, together with the
// data_ready / overrun_error handshake state.
// Ports:
//   clk            in   rising-edge clock
//   s_rst          in   synchronous active-high reset
//   load_buffer    in   1-cycle strobe from the FSM: capture packet_data
//   packet_data    in   payload to capture
//   data_read      in   host consumed rx_data (level)
//   rx_data        out  buffered byte
//   data_ready     out  rx_data holds an unread byte
//   overrun_error  out  an unread byte was overwritten
// ---------------------------------------------------------------------------
module rx_data_buff
  import rx_pkg::*;
#(
  parameter int DATA_BITS = RX_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic                 load_buffer,
  input  logic [DATA_BITS-1:0] packet_data,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error
);

  logic [DATA_BITS-1:0] r_rxData;
  logic                 r_dataReady;
  logic                 r_overrun;

  // Buffer and handshake flags. A load always wins and keeps data_ready set,
  // even if the host reads in the same cycle, because the new byte has not
  // been seen yet. Overrun is raised only when the byte being replaced was
  // still unread and is not being read right now; any read clears it.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_rxData    <= '0;
      r_dataReady <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (load_buffer) begin
      r_rxData    <= packet_data;
      r_dataReady <= 1'b1;
      r_overrun   <= ~data_read & (r_overrun | r_dataReady);
    end else if (data_read) begin
      r_dataReady <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_data       = r_rxData;
  assign data_ready    = r_dataReady;
  assign overrun_error = r_overrun;

endmodule

// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
// UART receive control unit: sequences one serial frame (start detect,
// shift-register clear, bit timing, stop/parity check, buffer load) and
// presents the byte through rx_data_buff.
// Optional feature macro: RX_PARITY_EN (even-parity check of each frame).
// Ports:
//   clk                 in   rising-edge clock
//   s_rst               in   synchronous active-high reset
//   start_bit_detected  in   1-cycle start pulse, honoured only in IDLE
//   packet_done         in   bit timer done, honoured only in RECEIVE
//   packet_data         in   received payload
//   stop_bit            in   received stop bit
//   parity_bit          in   received parity bit (RX_PARITY_EN only)
//   data_read           in   host consumed rx_data
//   enable_timer        out  bit timer run enable (RECEIVE)
//   sbc_clear           out  shift register / timer clear (CLEAR)
//   rx_data             out  buffered byte
//   data_ready          out  unread byte available
//   overrun_error       out  unread byte was overwritten
//   framing_error       out  last frame had a bad stop bit
//   parity_error        out  last frame had a parity mismatch
// ---------------------------------------------------------------------------
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS = RX_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic                 start_bit_detected,
  input  logic                 packet_done,
  input  logic [DATA_BITS-1:0] packet_data,
  input  logic                 stop_bit,
  input  logic                 parity_bit,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic                 sbc_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error
);

  rx_state_t r_state;
  rx_state_t w_stateNext;
  logic      w_loadBuffer;
  logic      w_parityBad;
  logic      w_frameBad;
  logic      r_framingError;
  logic      r_parityError;

`ifdef RX_PARITY_EN
  assign w_parityBad = parity_bit != (^packet_data ^ PARITY_ODD);
`else
  // Parity is not checked in this build; the port stays for a fixed pinout.
  assign w_parityBad = parity_bit & 1'b0;
`endif

  assign w_frameBad = ~stop_bit | w_parityBad;

  // State register; reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and Moore outputs. Each state lasts one cycle except IDLE
  // and RECEIVE, which wait on the start pulse and the bit timer.
  always_comb begin
    w_stateNext  = r_state;
    enable_timer = 1'b0;
    sbc_clear    = 1'b0;
    w_loadBuffer = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_bit_detected) w_stateNext = CLEAR;
      end
      CLEAR: begin
        sbc_clear   = 1'b1;
        w_stateNext = RECEIVE;
      end
      RECEIVE: begin
        enable_timer = 1'b1;
        if (packet_done) w_stateNext = CHECK;
      end
      CHECK: begin
        w_stateNext = w_frameBad ? IDLE : LOAD;
      end
      LOAD: begin
        w_loadBuffer = 1'b1;
        w_stateNext  = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Error flags describe the most recent frame: cleared when a new frame
  // starts and written from the check result in CHECK, so a good frame
  // leaves them clear and a bad one keeps them until the next start.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_framingError <= 1'b0;
      r_parityError  <= 1'b0;
    end else if (r_state == IDLE && start_bit_detected) begin
      r_framingError <= 1'b0;
      r_parityError  <= 1'b0;
    end else if (r_state == CHECK) begin
      r_framingError <= ~stop_bit;
      r_parityError  <= w_parityBad;
    end
  end

  assign framing_error = r_framingError;
  assign parity_error  = r_parityError;

  rx_data_buff #(
    .DATA_BITS(DATA_BITS)
  ) u_buff (
    .clk          (clk),
    .s_rst        (s_rst),
    .load_buffer  (w_loadBuffer),
    .packet_data  (packet_data),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Self-checking bench for rx_frame_ctrl: a table of frames with expected
// buffer/flag state, driven one by one through a scoreboard queue, followed
// by hand-written reset and parity sequences. Honours RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_rx_frame_ctrl;

  logic       clk;
  logic       s_rst;
  logic       start_bit_detected;
  logic       packet_done;
  logic [7:0] packet_data;
  logic       stop_bit;
  logic       parity_bit;
  logic       data_read;
  logic       enable_timer;
  logic       sbc_clear;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       parity_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       parityBit;
    logic       readInLoad;
    logic       readAfter;
    logic [7:0] expRxData;
    logic       expReady;
    logic       expOverrun;
    logic       expFraming;
    logic       expParity;
  } frame_t;

  frame_t vectors[9];
  frame_t scoreboard[$];

  rx_frame_ctrl #(
    .DATA_BITS(8)
  ) dut (
    .clk               (clk),
    .s_rst             (s_rst),
    .start_bit_detected(start_bit_detected),
    .packet_done       (packet_done),
    .packet_data       (packet_data),
    .stop_bit          (stop_bit),
    .parity_bit        (parity_bit),
    .data_read         (data_read),
    .enable_timer      (enable_timer),
    .sbc_clear         (sbc_clear),
    .rx_data           (rx_data),
    .data_ready        (data_ready),
    .overrun_error     (overrun_error),
    .framing_error     (framing_error),
    .parity_error      (parity_error)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns past the edge, where outputs are stable
  // and new inputs can be driven for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] data, input logic stopBit,
                                input logic parityBit, input logic readInLoad,
                                input logic readAfter, input logic [7:0] expRxData,
                                input logic expReady, input logic expOverrun,
                                input logic expFraming, input logic expParity);
    frame_t f;
    f.data       = data;
    f.stopBit    = stopBit;
    f.parityBit  = parityBit;
    f.readInLoad = readInLoad;
    f.readAfter  = readAfter;
    f.expRxData  = expRxData;
    f.expReady   = expReady;
    f.expOverrun = expOverrun;
    f.expFraming = expFraming;
    f.expParity  = expParity;
    return f;
  endfunction

  // Drive one complete frame and queue its expected result. The start pulse
  // is checked for the CLEAR and RECEIVE latencies on the way through; the
  // buffer result is visible three cycles after the packet_done cycle.
  task automatic applyStimulus(input frame_t f);
    scoreboard.push_back(f);
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    compare("sbcClear", {7'd0, sbc_clear}, 8'd1);
    compare("timerOffInClear", {7'd0, enable_timer}, 8'd0);
    compare("framingClearedAtStart", {7'd0, framing_error}, 8'd0);
    compare("parityClearedAtStart", {7'd0, parity_error}, 8'd0);
    tick();
    compare("timerOn", {7'd0, enable_timer}, 8'd1);
    compare("sbcClearOneCycle", {7'd0, sbc_clear}, 8'd0);
    tick();
    tick();
    packet_data = f.data;
    stop_bit    = f.stopBit;
    parity_bit  = f.parityBit;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    compare("timerOffInCheck", {7'd0, enable_timer}, 8'd0);
    tick();
    if (f.readInLoad) data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  // Pop the oldest expected frame result and compare it against the DUT.
  task automatic checkOutput();
    frame_t f;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardEmpty actual=0 expected=1 entry");
    end else begin
      f = scoreboard.pop_front();
      compare("rxData", rx_data, f.expRxData);
      compare("dataReady", {7'd0, data_ready}, {7'd0, f.expReady});
      compare("overrun", {7'd0, overrun_error}, {7'd0, f.expOverrun});
      compare("framing", {7'd0, framing_error}, {7'd0, f.expFraming});
      compare("parity", {7'd0, parity_error}, {7'd0, f.expParity});
    end
  endtask

  // One-cycle host read, then confirm both handshake flags dropped.
  task automatic hostRead();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    compare("readClearsReady", {7'd0, data_ready}, 8'd0);
    compare("readClearsOverrun", {7'd0, overrun_error}, 8'd0);
  endtask

  initial begin
    // Frame table; every payload here has an even number of ones, so the
    // correct even-parity bit is 0 and parity never faults in either build.
    vectors[0] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors[1] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors[2] = mk(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors[3] = mk(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors[4] = mk(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors[5] = mk(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors[6] = mk(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors[7] = mk(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    vectors[8] = mk(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0);

    s_rst              = 1'b1;
    start_bit_detected = 1'b0;
    packet_done        = 1'b0;
    packet_data        = 8'h00;
    stop_bit           = 1'b0;
    parity_bit         = 1'b0;
    data_read          = 1'b0;
    tick();
    tick();

    $display("[TB] reset state");
    compare("rstTimer", {7'd0, enable_timer}, 8'd0);
    compare("rstSbc", {7'd0, sbc_clear}, 8'd0);
    compare("rstRxData", rx_data, 8'h00);
    compare("rstReady", {7'd0, data_ready}, 8'd0);
    compare("rstOverrun", {7'd0, overrun_error}, 8'd0);
    compare("rstFraming", {7'd0, framing_error}, 8'd0);
    compare("rstParity", {7'd0, parity_error}, 8'd0);
    s_rst = 1'b0;
    tick();

    $display("[TB] frame table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vectors[i]);
      checkOutput();
      if (vectors[i].readAfter) hostRead();
      tick();
    end

    // Reset in the middle of a frame, with an unread byte and an overrun
    // pending; a start pulse during RECEIVE must be ignored first.
    $display("[TB] reset mid-frame");
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    tick();
    compare("midTimerOn", {7'd0, enable_timer}, 8'd1);
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    compare("startIgnoredTimer", {7'd0, enable_timer}, 8'd1);
    compare("startIgnoredSbc", {7'd0, sbc_clear}, 8'd0);
    s_rst = 1'b1;
    tick();
    compare("midRstTimer", {7'd0, enable_timer}, 8'd0);
    compare("midRstRxData", rx_data, 8'h00);
    compare("midRstReady", {7'd0, data_ready}, 8'd0);
    compare("midRstOverrun", {7'd0, overrun_error}, 8'd0);
    s_rst       = 1'b0;
    packet_data = 8'hAA;
    stop_bit    = 1'b1;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    tick();
    tick();
    tick();
    compare("doneIgnoredReady", {7'd0, data_ready}, 8'd0);
    compare("doneIgnoredRxData", rx_data, 8'h00);
    compare("doneIgnoredTimer", {7'd0, enable_timer}, 8'd0);
    compare("doneIgnoredSbc", {7'd0, sbc_clear}, 8'd0);

`ifdef RX_PARITY_EN
    // 8'h07 has three ones, so even parity needs parity_bit = 1.
    $display("[TB] parity checks");
    applyStimulus(mk(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    checkOutput();
    tick();
    applyStimulus(mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    checkOutput();
    tick();
    applyStimulus(mk(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0));
    checkOutput();
    tick();
`else
    // Without the parity feature a wrong parity bit must not matter.
    $display("[TB] parity ignored");
    applyStimulus(mk(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0));
    checkOutput();
    tick();
`endif

    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardLeftover actual=%0d expected=0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
